qed_replay_engine: RTL

Parametrised successor to the QED instruction path. It sits between the IFU and decode, the same slot the current QED top occupies. It passes original instructions through and captures QED-eligible ones in a DEPTH-entry replay buffer. At a sync point (control-flow or other non-eligible instruction, or buffer full) it stalls fetch and replays the captured sequence with registers remapped into the duplicate half of the register file (EDDI-V).

---
 rtl/qed_pkg.sv | 49 ++++
 rtl/qed_replay_fifo.sv | 60 ++++++
 rtl/qed_replay_engine.sv | 123 ++++++++++++
 3 files changed

// File: rtl/qed_pkg.sv
// Shared definitions for the QED replay engine: opcodes, instruction field
// positions, FSM state type and the EDDI-V register remap helper.
package qed_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;

    localparam int OPC_LSB = 0;
    localparam int OPC_W   = 7;
    localparam int RD_LSB  = 7;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int REG_W   = 5;

    typedef enum logic {
        ORIG = 1'b0,
        DUP  = 1'b1
    } qed_state_e;

    function automatic logic qed_is_eligible(input logic [6:0] opc);
        return opc inside {OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP};
    endfunction

    // Only register fields the format actually uses are moved; x0 stays x0
    // so hardwired-zero semantics survive in the duplicate.
    function automatic logic [31:0] qed_remap(input logic [31:0] insn,
                                              input logic [4:0]  offset);
        logic [31:0] r;
        logic [6:0]  opc;
        logic        use_rd;
        logic        use_rs1;
        logic        use_rs2;
        r       = insn;
        opc     = insn[OPC_LSB +: OPC_W];
        use_rd  = opc inside {OPC_LOAD, OPC_OPIMM, OPC_OP};
        use_rs1 = qed_is_eligible(opc);
        use_rs2 = opc inside {OPC_STORE, OPC_OP};
        if (use_rd && insn[RD_LSB +: REG_W] != '0)
            r[RD_LSB +: REG_W] = insn[RD_LSB +: REG_W] + offset;
        if (use_rs1 && insn[RS1_LSB +: REG_W] != '0)
            r[RS1_LSB +: REG_W] = insn[RS1_LSB +: REG_W] + offset;
        if (use_rs2 && insn[RS2_LSB +: REG_W] != '0)
            r[RS2_LSB +: REG_W] = insn[RS2_LSB +: REG_W] + offset;
        return r;
    endfunction

endpackage

// File: rtl/qed_replay_fifo.sv
// DEPTH x 32 replay buffer holding captured QED-eligible instructions.
// Pointers wrap naturally (DEPTH is a power of two); count separates full/empty.
module qed_replay_fifo
    import qed_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [31:0]            din_i,
    output logic [31:0]            dout_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push_ok;
    logic          pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is deliberately unreset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/qed_replay_engine.sv
// QED instruction path between IFU and decode: passes originals, captures
// eligible ones, replays them remapped at sync points. Optional: QED_STORE_SUPPRESS_EN.
module qed_replay_engine
    import qed_pkg::*;
#(
    parameter int          DEPTH      = 8,
    parameter int          REG_OFFSET = 16,
    parameter logic [31:0] NOP_INSN   = 32'h00000013
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ena,
    input  logic                   stall_IF,
    input  logic                   ifu_vld,
    input  logic [31:0]            ifu_qed_instruction,
    output logic [31:0]            qed_ifu_instruction,
    output logic                   vld_out,
    output logic                   qed_stall_fetch,
    output logic                   dup_mode,
    output logic [$clog2(DEPTH):0] buf_count
);

    localparam int         CW      = $clog2(DEPTH) + 1;
    localparam logic [4:0] OFFSET5 = 5'(REG_OFFSET);

`ifdef QED_STORE_SUPPRESS_EN
    localparam logic SUPPRESS_STORES = 1'b1;
`else
    localparam logic SUPPRESS_STORES = 1'b0;
`endif

    qed_state_e    state_q;
    logic          dup_mode_q;
    logic [31:0]   head;
    logic [31:0]   dup_insn;
    logic [CW-1:0] count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          is_elig;
    logic          capture_en;

    qed_replay_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (ifu_qed_instruction),
        .dout_o  (head),
        .count_o (count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign is_elig = qed_is_eligible(ifu_qed_instruction[OPC_LSB +: OPC_W]);

    // ena only matters when idle and empty; a partly filled buffer keeps
    // capturing until the next sync point drains it.
    assign capture_en = ena || !fifo_empty;

    assign dup_insn = (SUPPRESS_STORES && head[OPC_LSB +: OPC_W] == OPC_STORE)
                      ? NOP_INSN : qed_remap(head, OFFSET5);

    always_comb begin
        qed_ifu_instruction = ifu_qed_instruction;
        vld_out             = ifu_vld;
        qed_stall_fetch     = 1'b0;
        push                = 1'b0;
        pop                 = 1'b0;
        if (state_q == DUP) begin
            qed_ifu_instruction = dup_insn;
            vld_out             = 1'b1;
            qed_stall_fetch     = 1'b1;
            pop                 = !stall_IF;
        end else if (capture_en && ifu_vld) begin
            if (is_elig) begin
                push = !stall_IF && !fifo_full;
            end else if (!fifo_empty) begin
                // Hold the sync instruction in the IFU until the replay is done.
                vld_out         = 1'b0;
                qed_stall_fetch = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ORIG;
            dup_mode_q <= 1'b0;
        end else if (!stall_IF) begin
            case (state_q)
                ORIG: begin
                    if (capture_en && ifu_vld) begin
                        if (is_elig && count == CW'(DEPTH - 1)) begin
                            state_q    <= DUP;
                            dup_mode_q <= 1'b1;
                        end else if (!is_elig && !fifo_empty) begin
                            state_q    <= DUP;
                            dup_mode_q <= 1'b1;
                        end
                    end
                end
                DUP: begin
                    if (count == CW'(1)) begin
                        state_q    <= ORIG;
                        dup_mode_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= ORIG;
                    dup_mode_q <= 1'b0;
                end
            endcase
        end
    end

    assign dup_mode  = dup_mode_q;
    assign buf_count = count;

endmodule
